gpr_read_scoreboard: RTL and testbench

General-purpose register file and operand-read side for the MIPS core. It holds GPR[0..31] and accepts the writeback stage's single write port (address, data, enable). It serves two combinational read ports to decode, and bypasses same-cycle writeback data into those reads. A per-register pending counter tracks issued-but-not-written destinations, so decode can tell whether each operand is ready.

---
 rtl/gpr_pkg.sv | 8 +
 rtl/gpr_read_scoreboard_if.sv | 26 ++
 rtl/gpr_read_port.sv | 31 +++
 rtl/gpr_read_scoreboard.sv | 78 +++++++
 tb/tb_gpr_read_scoreboard.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/gpr_pkg.sv
// Shared GPR indexing definitions for the operand-read side of the core.
package gpr_pkg;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  localparam reg_idx_t REG_JAL  = 5'd31;
  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/gpr_read_scoreboard_if.sv
// Decode / writeback facing signals of the GPR read scoreboard.
interface gpr_read_scoreboard_if #(parameter int DW = 32);
  gpr_pkg::reg_idx_t ra_addr;
  gpr_pkg::reg_idx_t rb_addr;
  logic [DW-1:0]     ra_data;
  logic [DW-1:0]     rb_data;
  logic              ra_ready;
  logic              rb_ready;
  logic              iss_valid;
  gpr_pkg::reg_idx_t iss_addr;
  logic              iss_ready;
  logic              wb_en;
  gpr_pkg::reg_idx_t wb_addr;
  logic [DW-1:0]     wb_data;
  logic              busy;

  modport master (
    output ra_addr, rb_addr, iss_valid, iss_addr, wb_en, wb_addr, wb_data,
    input  ra_data, rb_data, ra_ready, rb_ready, iss_ready, busy
  );

  modport slave (
    input  ra_addr, rb_addr, iss_valid, iss_addr, wb_en, wb_addr, wb_data,
    output ra_data, rb_data, ra_ready, rb_ready, iss_ready, busy
  );
endinterface

// File: rtl/gpr_read_port.sv
// One combinational GPR read port: r0 forcing, writeback bypass and operand-ready.
module gpr_read_port
  import gpr_pkg::*;
#(
  parameter int DW = 32,
  parameter int PW = 2
) (
  input  reg_idx_t      addr,
  input  logic [DW-1:0] reg_val,
  input  logic [PW-1:0] pend_val,
  input  logic          wb_en,
  input  reg_idx_t      wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] data,
  output logic          ready
);
  logic hit;

  always_comb begin
    hit = wb_en && (wb_addr == addr);
    if (addr == REG_ZERO)
      data = '0;
    else if (hit)
      data = wb_data;
    else
      data = reg_val;
    // A single outstanding write landing this cycle is covered by the bypass.
    ready = (addr == REG_ZERO) || (pend_val == '0) ||
            ((pend_val == PW'(1)) && hit);
  end
endmodule

// File: rtl/gpr_read_scoreboard.sv
// GPR file with one writeback port, two bypassed read ports and per-register
// pending-write counters for decode's operand-ready scoreboard.
module gpr_read_scoreboard #(
  parameter int NREG = gpr_pkg::NREG,
  parameter int DW   = 32,
  parameter int PW   = 2
) (
  input logic            clk,
  input logic            rst_n,
  gpr_read_scoreboard_if.slave bus
);
  import gpr_pkg::*;

  localparam logic [PW-1:0] PMAX = '1;

  logic [DW-1:0] regs [NREG];
  logic [PW-1:0] pend [NREG];
  logic [NREG-1:0] inc, dec;
  logic iss_rdy, iss_acc, busy_c;

  always_comb begin
    // A saturated counter draining this same cycle frees a slot for the issue.
    iss_rdy = (bus.iss_addr == REG_ZERO) || (pend[bus.iss_addr] != PMAX) ||
              (bus.wb_en && (bus.wb_addr == bus.iss_addr));
    iss_acc = bus.iss_valid && iss_rdy;
    inc     = '0;
    dec     = '0;
    busy_c  = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      inc[r] = iss_acc && (bus.iss_addr == reg_idx_t'(r));
      dec[r] = bus.wb_en && (bus.wb_addr == reg_idx_t'(r)) && (pend[r] != '0);
      busy_c = busy_c || (pend[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (bus.wb_en && (bus.wb_addr == reg_idx_t'(r)))
          regs[r] <= bus.wb_data;
        if (inc[r] && !dec[r])
          pend[r] <= pend[r] + PW'(1);
        else if (dec[r] && !inc[r])
          pend[r] <= pend[r] - PW'(1);
      end
    end
  end

  assign bus.iss_ready = iss_rdy;
  assign bus.busy      = busy_c;

  gpr_read_port #(.DW(DW), .PW(PW)) u_port_a (
    .addr     (bus.ra_addr),
    .reg_val  (regs[bus.ra_addr]),
    .pend_val (pend[bus.ra_addr]),
    .wb_en    (bus.wb_en),
    .wb_addr  (bus.wb_addr),
    .wb_data  (bus.wb_data),
    .data     (bus.ra_data),
    .ready    (bus.ra_ready)
  );

  gpr_read_port #(.DW(DW), .PW(PW)) u_port_b (
    .addr     (bus.rb_addr),
    .reg_val  (regs[bus.rb_addr]),
    .pend_val (pend[bus.rb_addr]),
    .wb_en    (bus.wb_en),
    .wb_addr  (bus.wb_addr),
    .wb_data  (bus.wb_data),
    .data     (bus.rb_data),
    .ready    (bus.rb_ready)
  );
endmodule

// File: tb/tb_gpr_read_scoreboard.sv
// Directed plus randomized bench for gpr_read_scoreboard against an array/count model.
module tb_gpr_read_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   last_acc = 1'b0;

  logic [31:0] m_regs [32];
  int          m_pend [32];

  gpr_read_scoreboard_if #(.DW(32)) bus ();

  gpr_read_scoreboard #(.NREG(32), .DW(32), .PW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int a);
    if (a == 0) return 32'd0;
    if (bus.wb_en && bus.wb_addr == 5'(a)) return bus.wb_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_ready(input int a);
    if (a == 0) return 1'b1;
    if (m_pend[a] == 0) return 1'b1;
    return (m_pend[a] == 1) && bus.wb_en && (bus.wb_addr == 5'(a));
  endfunction

  function automatic logic exp_iss_ready();
    int a = int'(bus.iss_addr);
    if (a == 0) return 1'b1;
    if (m_pend[a] < 3) return 1'b1;
    return bus.wb_en && (bus.wb_addr == 5'(a));
  endfunction

  function automatic logic exp_busy();
    for (int r = 1; r < 32; r++)
      if (m_pend[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'd0;
      m_pend[r] = 0;
    end
  endtask

  task automatic set_in(input int ra, input int rb, input bit iv, input int ia,
                        input bit we, input int wa, input logic [31:0] wd);
    bus.ra_addr   = 5'(ra);
    bus.rb_addr   = 5'(rb);
    bus.iss_valid = iv;
    bus.iss_addr  = 5'(ia);
    bus.wb_en     = we;
    bus.wb_addr   = 5'(wa);
    bus.wb_data   = wd;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".ra_data"},   bus.ra_data,         exp_data(int'(bus.ra_addr)));
    check_eq({tag, ".rb_data"},   bus.rb_data,         exp_data(int'(bus.rb_addr)));
    check_eq({tag, ".ra_ready"},  32'(bus.ra_ready),   32'(exp_ready(int'(bus.ra_addr))));
    check_eq({tag, ".rb_ready"},  32'(bus.rb_ready),   32'(exp_ready(int'(bus.rb_addr))));
    check_eq({tag, ".iss_ready"}, 32'(bus.iss_ready),  32'(exp_iss_ready()));
    check_eq({tag, ".busy"},      32'(bus.busy),       32'(exp_busy()));
  endtask

  // Inputs are applied at the falling edge; check mid-low-phase, then advance the model.
  task automatic cyc(input string tag);
    bit acc;
    int inc, dec;
    #2;
    check_outputs(tag);
    acc = bus.iss_valid && exp_iss_ready();
    @(posedge clk);
    for (int r = 1; r < 32; r++) begin
      inc = (acc && bus.iss_addr == 5'(r)) ? 1 : 0;
      dec = (bus.wb_en && bus.wb_addr == 5'(r) && m_pend[r] != 0) ? 1 : 0;
      m_pend[r] = m_pend[r] + inc - dec;
      if (bus.wb_en && bus.wb_addr == 5'(r)) m_regs[r] = bus.wb_data;
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  function automatic int pick_addr();
    int hot [5] = '{0, 4, 9, 12, 31};
    if ($urandom_range(0, 2) != 0) return hot[$urandom_range(0, 4)];
    return int'($urandom_range(0, 31));
  endfunction

  initial begin
    model_clear();
    set_in(0, 5, 0, 0, 0, 0, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst");

    set_in(8, 5, 0, 0, 1, 8, 32'hDEAD_BEEF);
    cyc("wb8_bypass");
    set_in(8, 0, 0, 0, 0, 0, 32'd0);
    cyc("rd8_reg");
    set_in(0, 0, 0, 0, 1, 0, 32'h1234_5678);
    cyc("wb0");
    set_in(0, 0, 0, 0, 0, 0, 32'd0);
    cyc("rd0");

    set_in(0, 9, 1, 9, 0, 0, 32'd0);
    cyc("iss9");
    set_in(0, 9, 0, 0, 0, 0, 32'd0);
    cyc("pend9");
    set_in(0, 9, 0, 0, 1, 9, 32'd7);
    cyc("wb9");
    set_in(0, 9, 0, 0, 0, 0, 32'd0);
    cyc("idle9");

    for (int i = 0; i < 3; i++) begin
      set_in(31, 0, 1, 31, 0, 0, 32'd0);
      cyc("iss31");
    end
    set_in(31, 0, 1, 31, 0, 0, 32'd0);
    cyc("iss31_full");
    set_in(31, 0, 1, 31, 1, 31, 32'h0000_0100);
    cyc("iss31_drain");
    for (int i = 0; i < 3; i++) begin
      set_in(31, 31, 0, 0, 1, 31, 32'h0000_0200 + 32'(i));
      cyc("wb31");
    end
    set_in(31, 31, 0, 0, 0, 0, 32'd0);
    cyc("idle31");

    set_in(12, 0, 1, 12, 0, 0, 32'd0);
    cyc("iss12");
    set_in(12, 0, 1, 12, 1, 12, 32'hAAAA_0012);
    cyc("iss_wb12");
    set_in(12, 0, 0, 0, 0, 0, 32'd0);
    cyc("pend12");
    set_in(12, 0, 0, 0, 1, 12, 32'hBBBB_0012);
    cyc("wb12");

    set_in(4, 4, 1, 4, 0, 0, 32'd0);
    cyc("iss4a");
    cyc("iss4b");
    set_in(4, 8, 0, 0, 0, 0, 32'd0);
    cyc("pend4");
    rst_n = 1'b0;
    model_clear();
    #2;
    check_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    set_in(4, 8, 0, 0, 1, 4, 32'hCAFE_0004);
    cyc("wb4_after_rst");
    set_in(4, 4, 0, 0, 0, 0, 32'd0);
    cyc("rd4");

    for (int i = 0; i < 600; i++) begin
      bit keep = bus.iss_valid && !last_acc;
      int ia   = keep ? int'(bus.iss_addr) : pick_addr();
      bit iv   = keep ? 1'b1 : ($urandom_range(0, 9) < 4);
      set_in(pick_addr(), pick_addr(), iv, ia, ($urandom_range(0, 1) == 1),
             pick_addr(), $urandom);
      cyc("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
